// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive-side UART controller.
// Synchronises the raw serial line, detects the start-bit falling edge,
// enables the downstream baud counter (count_sig) for the length of a frame
// and samples each bit on that counter's mid-bit bps_clk strobe. A completed
// frame is delivered with a one-cycle rx_done pulse plus error flags.
// Optional feature macro: UART_RX_PARITY_EN adds one even-parity bit between
// the data and stop bits, a PARITY state and the parity_err port.
//
// Handshake: there is no back-pressure. rx_done is a one-cycle strobe;
// frame_err/parity_err are meaningful only while rx_done is high, and rx_data
// holds the last word until the next rx_done.
module uart_rx_ctrl #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 bps_clk,
  output logic                 count_sig,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy,
  output logic [2:0]           dbg_state
);

  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_rx_s1;
  logic                 r_rx_s2;
  logic                 r_rx_s3;
  logic                 w_fall;
  logic [DATA_BITS-1:0] r_shift;
  logic [IDX_W-1:0]     r_bit_idx;
  logic                 r_count_sig;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_done;
  logic                 r_frame_err;
`ifdef UART_RX_PARITY_EN
  logic                 r_par_calc;
  logic                 r_parity_err;
`endif

  // Two-flop synchroniser plus a history flop for edge detection; idle high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_s3 <= 1'b1;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_s3 <= r_rx_s2;
    end
  end

  // A held-low line never produces another edge, so a break cannot restart.
  assign w_fall = r_rx_s3 & ~r_rx_s2;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic; edges are only looked at in IDLE, so falls while busy are ignored.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_fall) w_state_next = S_START;
      end
      S_START: begin
        if (bps_clk) w_state_next = r_rx_s2 ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (bps_clk && (r_bit_idx == LAST_IDX)) begin
`ifdef UART_RX_PARITY_EN
          w_state_next = S_PARITY;
`else
          w_state_next = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (bps_clk) w_state_next = S_STOP;
      end
`endif
      S_STOP: begin
        if (bps_clk) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Frame datapath: counter enable, bit shifting and registered result strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count_sig  <= 1'b0;
      r_shift      <= '0;
      r_bit_idx    <= '0;
      r_rx_data    <= '0;
      r_rx_done    <= 1'b0;
      r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_calc   <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      // Counter enable tracks "FSM will be out of IDLE", so it rises on the
      // edge that leaves IDLE and drops on the edge that returns there.
      r_count_sig <= (w_state_next != S_IDLE);
      r_rx_done   <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      if (bps_clk) begin
        case (r_state)
          S_START: begin
            if (!r_rx_s2) r_bit_idx <= '0;
          end
          S_DATA: begin
            // LSB arrives first; shifting in at the MSB leaves it at bit 0.
            r_shift   <= {r_rx_s2, r_shift[DATA_BITS-1:1]};
            r_bit_idx <= r_bit_idx + IDX_W'(1);
          end
`ifdef UART_RX_PARITY_EN
          S_PARITY: begin
            // Even parity: data bits XOR parity bit must be zero.
            r_par_calc <= (^r_shift) ^ r_rx_s2;
          end
`endif
          S_STOP: begin
            r_rx_data   <= r_shift;
            r_frame_err <= ~r_rx_s2;
            r_rx_done   <= 1'b1;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= r_par_calc;
`endif
          end
          default: ;
        endcase
      end
    end
  end

  assign count_sig  = r_count_sig;
  assign rx_data    = r_rx_data;
  assign rx_done    = r_rx_done;
  assign frame_err  = r_frame_err;
`ifdef UART_RX_PARITY_EN
  assign parity_err = r_parity_err;
`endif
  assign busy       = (r_state != S_IDLE);
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Testbench for uart_rx_ctrl with a behavioural baud counter attached.
// The counter keeps the real contract shape (wrap every BIT_CLKS, strobe at
// MID, clear when disabled) with a shortened bit period so the run stays short;
// the DUT only ever sees bps_clk, so the period itself is not design-visible.
module tb_uart_rx_ctrl;

  localparam int DATA_BITS = 8;
  localparam int BIT_CLKS  = 209;
  localparam int MID       = 104;
  localparam int GLITCH    = 20;
  localparam int W         = DATA_BITS + 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 rx  = 1'b1;
  logic                 bps_clk;
  logic                 count_sig;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_done;
  logic                 frame_err;
  logic                 busy;
  logic [2:0]           dbg_state;
`ifdef UART_RX_PARITY_EN
  logic                 parity_err;
`endif

  // Expected word layout: {parity_err, frame_err, data}.
  logic [W-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_err  = 0;
  int n_done = 0;

  uart_rx_ctrl #(.DATA_BITS(DATA_BITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .bps_clk   (bps_clk),
    .count_sig (count_sig),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock / reset block.
  always #5 clk = ~clk;

  // Baud counter model.
  logic [11:0] r_baud_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             r_baud_cnt <= '0;
    else if (!count_sig)                 r_baud_cnt <= '0;
    else if (r_baud_cnt == BIT_CLKS - 1) r_baud_cnt <= '0;
    else                                 r_baud_cnt <= r_baud_cnt + 12'd1;
  end
  assign bps_clk = (r_baud_cnt == 12'(MID));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks.
  task automatic hold_bit(input logic v);
    rx = v;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_bit, input logic stop_bit);
    hold_bit(1'b0);
    for (int i = 0; i < DATA_BITS; i++) hold_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    hold_bit(par_bit);
`else
    if (par_bit) begin end
`endif
    hold_bit(stop_bit);
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic par_bit, input logic stop_bit);
    logic perr;
`ifdef UART_RX_PARITY_EN
    perr = (^d) ^ par_bit;
`else
    perr = 1'b0;
    if (par_bit) begin end
`endif
    exp_q.push_back({perr, ~stop_bit, d});
  endtask

  // Scoreboard monitor: pops one expectation per rx_done pulse.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst && rx_done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(rx_data), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("rx_data", 32'(rx_data), 32'(e[DATA_BITS-1:0]));
        check("frame_err", 32'(frame_err), 32'(e[DATA_BITS]));
`ifdef UART_RX_PARITY_EN
        check("parity_err", 32'(parity_err), 32'(e[DATA_BITS+1]));
`endif
      end
      @(negedge clk);
      check("done_one_cycle", 32'(rx_done), 32'd0);
      check("cs_after_done", 32'(count_sig), 32'd0);
      check("busy_after_done", 32'(busy), 32'd0);
    end
  end

  initial begin
    int t;
    int done0;
    logic busy_seen;
    logic [7:0] d55;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_count_sig", 32'(count_sig), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rx_done", 32'(rx_done), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);

    // 0xA5, good frame.
    expect_frame(8'hA5, ^8'hA5, 1'b1);
    send_frame(8'hA5, ^8'hA5, 1'b1);
    repeat (BIT_CLKS) @(negedge clk);
    check("a5_done_count", 32'(n_done), 32'd1);

    // Short low glitch on idle line.
    done0 = n_done;
    rx = 1'b0;
    t = 0;
    while (!count_sig && t < 10) begin @(negedge clk); t++; end
    check("glitch_cs_rise", 32'(count_sig), 32'd1);
    repeat (GLITCH - t) @(negedge clk);
    rx = 1'b1;
    t = 0;
    while (count_sig && t < 2 * BIT_CLKS) begin @(negedge clk); t++; end
    check("glitch_cs_fall", 32'(count_sig), 32'd0);
    check("glitch_cs_len", 32'(t >= MID - GLITCH && t <= MID + 4), 32'd1);
    repeat (BIT_CLKS) @(negedge clk);
    check("glitch_no_done", 32'(n_done), 32'(done0));
    check("glitch_data_kept", 32'(rx_data), 32'hA5);
    check("glitch_idle", 32'(busy), 32'd0);

    // 0x3C with stop bit 0, then a 10-bit-time break.
    expect_frame(8'h3C, ^8'h3C, 1'b0);
    send_frame(8'h3C, ^8'h3C, 1'b0);
    busy_seen = 1'b0;
    repeat (10 * BIT_CLKS) begin
      @(negedge clk);
      if (busy || count_sig) busy_seen = 1'b1;
    end
    check("break_no_restart", 32'(busy_seen), 32'd0);
    check("ferr_done_count", 32'(n_done), 32'd2);
    rx = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);

    // Back-to-back 0x00 then 0xFF.
    expect_frame(8'h00, 1'b0, 1'b1);
    expect_frame(8'hFF, ^8'hFF, 1'b1);
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, ^8'hFF, 1'b1);
    repeat (BIT_CLKS) @(negedge clk);
    check("b2b_done_count", 32'(n_done), 32'd4);
    check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of data bit 4 of 0x55.
    d55 = 8'h55;
    hold_bit(1'b0);
    for (int i = 0; i < 4; i++) hold_bit(d55[i]);
    rx = d55[4];
    repeat (BIT_CLKS / 2) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_count_sig", 32'(count_sig), 32'd0);
    check("midrst_rx_data", 32'(rx_data), 32'd0);
    check("midrst_rx_done", 32'(rx_done), 32'd0);
    check("midrst_frame_err", 32'(frame_err), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'd0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2 * BIT_CLKS) @(negedge clk);
    check("post_rst_no_done", 32'(n_done), 32'd4);

    expect_frame(8'h81, ^8'h81, 1'b1);
    send_frame(8'h81, ^8'h81, 1'b1);
    repeat (BIT_CLKS) @(negedge clk);
    check("x81_done_count", 32'(n_done), 32'd5);

`ifdef UART_RX_PARITY_EN
    // Parity: 0x07 has three ones, so parity bit 1 is good and 0 is bad.
    expect_frame(8'h07, 1'b1, 1'b1);
    send_frame(8'h07, 1'b1, 1'b1);
    expect_frame(8'h07, 1'b0, 1'b1);
    send_frame(8'h07, 1'b0, 1'b1);
    repeat (BIT_CLKS) @(negedge clk);
    check("parity_done_count", 32'(n_done), 32'd7);
`endif

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
